// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave FSM state type.
package ahb_pkg;

   localparam logic [1:0] RSP_OKAY  = 2'b00;
   localparam logic [1:0] RSP_ERROR = 2'b01;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } dslv_state_t;

endpackage

// File: rtl/ahb_errlog_capture.sv
// Fault log: first-fault address/direction, overflow flag and a saturating count.
module ahb_errlog_capture #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  cap,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  write,
   input  logic                  clr,
   output logic                  err_valid,
   output logic                  err_ovf,
   output logic [ADDR_WIDTH-1:0] err_addr,
   output logic                  err_write,
   output logic [CNT_WIDTH-1:0]  err_count
);

   logic                  err_valid_q, err_valid_d;
   logic                  err_ovf_q, err_ovf_d;
   logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
   logic                  err_write_q, err_write_d;
   logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;

   // A capture in the same cycle as a clear behaves as the first fault after the clear.
   always_comb begin
      err_valid_d = err_valid_q;
      err_ovf_d   = err_ovf_q;
      err_addr_d  = err_addr_q;
      err_write_d = err_write_q;
      err_count_d = err_count_q;
      if (clr) begin
         err_valid_d = 1'b0;
         err_ovf_d   = 1'b0;
         err_count_d = '0;
      end
      if (cap) begin
         if (!err_valid_q || clr) begin
            err_valid_d = 1'b1;
            err_addr_d  = addr;
            err_write_d = write;
         end else begin
            err_ovf_d = 1'b1;
         end
         if (clr) begin
            err_count_d = CNT_WIDTH'(1);
         end else if (err_count_q != '1) begin
            err_count_d = err_count_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_valid_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_addr_q  <= '0;
         err_write_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         err_valid_q <= err_valid_d;
         err_ovf_q   <= err_ovf_d;
         err_addr_q  <= err_addr_d;
         err_write_q <= err_write_d;
         err_count_q <= err_count_d;
      end
   end

   assign err_valid = err_valid_q;
   assign err_ovf   = err_ovf_q;
   assign err_addr  = err_addr_q;
   assign err_write = err_write_q;
   assign err_count = err_count_q;

endmodule

// File: rtl/ahb_default_slave_errlog.sv
// AHB-Lite default slave: optional wait states then a two-cycle ERROR, with fault logging.
// Handshake: a transfer is taken when HSEL & HREADY & HTRANS is NONSEQ/SEQ while HREADYOUT=1.
module ahb_default_slave_errlog
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int WAIT_STATES = 0,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [1:0]            HTRANS,
   input  logic                  HREADY,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic                  HWRITE,
   input  logic                  ERR_CLR,
   output logic                  HREADYOUT,
   output logic [1:0]            HRESP,
   output logic                  ERR_VALID,
   output logic                  ERR_OVF,
   output logic [ADDR_WIDTH-1:0] ERR_ADDR,
   output logic                  ERR_WRITE,
   output logic [CNT_WIDTH-1:0]  ERR_COUNT,
   output logic                  IRQ
);

   if (WAIT_STATES < 0 || WAIT_STATES > 15 || CNT_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_bad_param
      $error("ahb_default_slave_errlog: illegal parameter value");
   end

   localparam int          WAIT_LOAD_INT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
   localparam logic [3:0]  WAIT_LOAD     = 4'(WAIT_LOAD_INT);

   dslv_state_t state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        hreadyout_q, hreadyout_d;
   logic [1:0]  hresp_q, hresp_d;
   logic        invalid;
   logic        capture;

   assign invalid = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      capture    = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_ERR2: begin
            if (invalid) begin
               capture = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_d    = ST_WAIT;
                  wait_cnt_d = WAIT_LOAD;
               end else begin
                  state_d = ST_ERR1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q == 4'd0) state_d = ST_ERR1;
            else                    wait_cnt_d = wait_cnt_q - 4'd1;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
      // Outputs are decoded from the next state so they come straight from flops.
      hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
      hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? RSP_ERROR : RSP_OKAY;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= 4'd0;
         hreadyout_q <= 1'b1;
         hresp_q     <= RSP_OKAY;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   end

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;

   ahb_errlog_capture #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_capture (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .cap       (capture),
      .addr      (HADDR),
      .write     (HWRITE),
      .clr       (ERR_CLR),
      .err_valid (ERR_VALID),
      .err_ovf   (ERR_OVF),
      .err_addr  (ERR_ADDR),
      .err_write (ERR_WRITE),
      .err_count (ERR_COUNT)
   );

   assign IRQ = ERR_VALID;

endmodule

// File: tb/tb_ahb_default_slave_errlog.sv
// Bench for the AHB default slave: three instances (W=0, W=3, 2-bit counter) on shared inputs.
module tb_ahb_default_slave_errlog;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL = 1'b0;
   logic [1:0]  HTRANS = 2'b00;
   logic        HREADY = 1'b1;
   logic [31:0] HADDR = '0;
   logic        HWRITE = 1'b0;
   logic        ERR_CLR = 1'b0;

   logic        rdy [3];
   logic [1:0]  rsp [3];
   logic        vld [3];
   logic        ovf [3];
   logic [31:0] ead [3];
   logic        ewr [3];
   logic        irq [3];
   logic [7:0]  cnt0, cnt3;
   logic [1:0]  cntc;

   int n_cmp = 0;
   int n_mis = 0;
   logic [7:0] exp_q[$];

   always #5 HCLK = ~HCLK;

   ahb_default_slave_errlog #(.ADDR_WIDTH(32), .WAIT_STATES(0), .CNT_WIDTH(8)) u_w0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HREADY(HREADY),
      .HADDR(HADDR), .HWRITE(HWRITE), .ERR_CLR(ERR_CLR), .HREADYOUT(rdy[0]), .HRESP(rsp[0]),
      .ERR_VALID(vld[0]), .ERR_OVF(ovf[0]), .ERR_ADDR(ead[0]), .ERR_WRITE(ewr[0]),
      .ERR_COUNT(cnt0), .IRQ(irq[0]));

   ahb_default_slave_errlog #(.ADDR_WIDTH(32), .WAIT_STATES(3), .CNT_WIDTH(8)) u_w3 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HREADY(HREADY),
      .HADDR(HADDR), .HWRITE(HWRITE), .ERR_CLR(ERR_CLR), .HREADYOUT(rdy[1]), .HRESP(rsp[1]),
      .ERR_VALID(vld[1]), .ERR_OVF(ovf[1]), .ERR_ADDR(ead[1]), .ERR_WRITE(ewr[1]),
      .ERR_COUNT(cnt3), .IRQ(irq[1]));

   ahb_default_slave_errlog #(.ADDR_WIDTH(32), .WAIT_STATES(0), .CNT_WIDTH(2)) u_c2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HREADY(HREADY),
      .HADDR(HADDR), .HWRITE(HWRITE), .ERR_CLR(ERR_CLR), .HREADYOUT(rdy[2]), .HRESP(rsp[2]),
      .ERR_VALID(vld[2]), .ERR_OVF(ovf[2]), .ERR_ADDR(ead[2]), .ERR_WRITE(ewr[2]),
      .ERR_COUNT(cntc), .IRQ(irq[2]));

   typedef struct {
      logic [1:0]  trans;
      logic        sel;
      logic        rdyi;
      logic [31:0] addr;
      logic        wr;
      logic        clr;
      logic        e_rdy;
      logic [1:0]  e_rsp;
      logic        e_vld;
      logic        e_ovf;
      logic [31:0] e_addr;
      logic        e_wr;
      logic [7:0]  e_cnt;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] t, input logic s, input logic r, input logic [31:0] a,
                        input logic w, input logic c);
      @(negedge HCLK);
      HTRANS = t; HSEL = s; HREADY = r; HADDR = a; HWRITE = w; ERR_CLR = c;
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic do_reset();
      @(negedge HCLK);
      HRESETn = 1'b0;
      HTRANS = 2'b00; HSEL = 1'b0; HREADY = 1'b1; HADDR = '0; HWRITE = 1'b0; ERR_CLR = 1'b0;
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
   endtask

   initial begin
      // trans sel rdy addr wr clr | rdy rsp vld ovf addr wr cnt   (checked on the W=0 instance)
      vecs[0]  = '{2'd0, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 8'd0};
      vecs[1]  = '{2'd1, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 8'd0};
      vecs[2]  = '{2'd2, 1'b1, 1'b0, 32'h5000,      1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 8'd0};
      vecs[3]  = '{2'd2, 1'b0, 1'b1, 32'h5000,      1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 8'd0};
      vecs[4]  = '{2'd2, 1'b1, 1'b1, 32'h4000_0010, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 32'h4000_0010, 1'b1, 8'd1};
      vecs[5]  = '{2'd0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h4000_0010, 1'b1, 8'd1};
      vecs[6]  = '{2'd0, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h4000_0010, 1'b1, 8'd1};
      vecs[7]  = '{2'd2, 1'b1, 1'b1, 32'h100,       1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 32'h4000_0010, 1'b1, 8'd2};
      vecs[8]  = '{2'd0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 32'h4000_0010, 1'b1, 8'd2};
      vecs[9]  = '{2'd3, 1'b1, 1'b1, 32'h200,       1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 32'h4000_0010, 1'b1, 8'd3};
      vecs[10] = '{2'd0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 32'h4000_0010, 1'b1, 8'd3};
      vecs[11] = '{2'd0, 1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h4000_0010, 1'b1, 8'd0};
      vecs[12] = '{2'd2, 1'b1, 1'b1, 32'h100,       1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 32'h100,       1'b0, 8'd1};
      vecs[13] = '{2'd0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h100,       1'b0, 8'd1};
      vecs[14] = '{2'd3, 1'b1, 1'b1, 32'h200,       1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 32'h100,       1'b0, 8'd2};
      vecs[15] = '{2'd0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 32'h100,       1'b0, 8'd2};
      vecs[16] = '{2'd0, 1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 32'h100,       1'b0, 8'd2};

      // Reset state
      do_reset();
      #1;
      chk("reset rdy", 32'(rdy[0]), 32'h1);
      chk("reset rsp", 32'(rsp[0]), 32'h0);
      chk("reset vld", 32'(vld[0]), 32'h0);
      chk("reset ovf", 32'(ovf[0]), 32'h0);
      chk("reset addr", ead[0], 32'h0);
      chk("reset cnt", 32'(cnt0), 32'h0);
      chk("reset irq", 32'(irq[0]), 32'h0);

      // Table: ignored transfers, single fault, back-to-back faults, clear
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].trans, vecs[i].sel, vecs[i].rdyi, vecs[i].addr, vecs[i].wr, vecs[i].clr);
         step();
         chk($sformatf("v%0d rdy", i), 32'(rdy[0]), 32'(vecs[i].e_rdy));
         chk($sformatf("v%0d rsp", i), 32'(rsp[0]), 32'(vecs[i].e_rsp));
         chk($sformatf("v%0d vld", i), 32'(vld[0]), 32'(vecs[i].e_vld));
         chk($sformatf("v%0d irq", i), 32'(irq[0]), 32'(vecs[i].e_vld));
         chk($sformatf("v%0d ovf", i), 32'(ovf[0]), 32'(vecs[i].e_ovf));
         chk($sformatf("v%0d addr", i), ead[0], vecs[i].e_addr);
         chk($sformatf("v%0d wr", i), 32'(ewr[0]), 32'(vecs[i].e_wr));
         chk($sformatf("v%0d cnt", i), 32'(cnt0), 32'(vecs[i].e_cnt));
      end

      // WAIT_STATES=3 read: three OKAY waits, then ERROR low, then ERROR high
      do_reset();
      drive(2'd2, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
      step();
      chk("w3 vld", 32'(vld[1]), 32'h1);
      chk("w3 addr", ead[1], 32'h40);
      chk("w3 wr", 32'(ewr[1]), 32'h0);
      begin
         logic [5:0] e_rdy;
         logic [5:0] e_err;
         e_rdy = 6'b110000;
         e_err = 6'b011000;
         for (int j = 0; j < 6; j++) begin
            chk($sformatf("w3 c%0d rdy", j + 1), 32'(rdy[1]), 32'(e_rdy[j]));
            chk($sformatf("w3 c%0d rsp", j + 1), 32'(rsp[1]), e_err[j] ? 32'h1 : 32'h0);
            drive(2'd0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
            step();
         end
      end

      // 2-bit counter saturation, then clear coinciding with a new fault
      do_reset();
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back((k < 3) ? 8'(k + 1) : 8'd3);
      end
      for (int k = 0; k < 5; k++) begin
         drive(2'd2, 1'b1, 1'b1, 32'h1000 + 32'(k), 1'b0, 1'b0);
         step();
         chk($sformatf("sat f%0d rsp", k + 1), 32'(rsp[2]), 32'h1);
         chk($sformatf("sat f%0d cnt", k + 1), 32'(cntc), 32'(exp_q.pop_front()));
         drive(2'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         step();
      end
      chk("sat ovf", 32'(ovf[2]), 32'h1);
      chk("sat addr", ead[2], 32'h1000);
      drive(2'd2, 1'b1, 1'b1, 32'h300, 1'b1, 1'b1);
      step();
      chk("clrcap cnt", 32'(cntc), 32'h1);
      chk("clrcap ovf", 32'(ovf[2]), 32'h0);
      chk("clrcap vld", 32'(vld[2]), 32'h1);
      chk("clrcap addr", ead[2], 32'h300);
      chk("clrcap wr", 32'(ewr[2]), 32'h1);
      drive(2'd0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
      step();

      // Asynchronous reset during ERR1, then a fresh fault
      do_reset();
      drive(2'd2, 1'b1, 1'b1, 32'h80, 1'b1, 1'b0);
      step();
      chk("ar err1 rdy", 32'(rdy[0]), 32'h0);
      chk("ar err1 rsp", 32'(rsp[0]), 32'h1);
      #1;
      HRESETn = 1'b0;
      #1;
      chk("ar rdy", 32'(rdy[0]), 32'h1);
      chk("ar rsp", 32'(rsp[0]), 32'h0);
      chk("ar vld", 32'(vld[0]), 32'h0);
      chk("ar addr", ead[0], 32'h0);
      chk("ar wr", 32'(ewr[0]), 32'h0);
      chk("ar cnt", 32'(cnt0), 32'h0);
      chk("ar irq", 32'(irq[0]), 32'h0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      HTRANS = 2'd2; HSEL = 1'b1; HREADY = 1'b1; HADDR = 32'h90; HWRITE = 1'b0; ERR_CLR = 1'b0;
      step();
      chk("post rst c1 rdy", 32'(rdy[0]), 32'h0);
      chk("post rst c1 rsp", 32'(rsp[0]), 32'h1);
      chk("post rst addr", ead[0], 32'h90);
      drive(2'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      chk("post rst c2 rdy", 32'(rdy[0]), 32'h1);
      chk("post rst c2 rsp", 32'(rsp[0]), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/ahb_default_slave_errlog.md
# ahb_default_slave_errlog

Parametrised AHB-Lite default slave for the L1 bus matrix. It answers every NONSEQ/SEQ transfer that decodes to an unmapped region with a standard two-cycle ERROR response, optionally preceded by programmable wait states. It also records the first faulting address and direction, and counts faults. The log is exposed as sideband status plus an interrupt so core firmware can diagnose bus faults.

## Interface
- ADDR_WIDTH, 32, width of HADDR and ERR_ADDR
- WAIT_STATES, 0, HREADYOUT-low OKAY cycles inserted before the ERROR response (0..15)
- CNT_WIDTH, 8, width of saturating fault counter ERR_COUNT
- HCLK  in  1  AHB clock
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL  in  1  default-slave select from matrix decoder
- HTRANS  in  2  transfer type
- HREADY  in  1  bus ready (transfer-done) input
- HADDR  in  ADDR_WIDTH  transfer address
- HWRITE  in  1  transfer direction
- ERR_CLR  in  1  single-cycle pulse, clears the log
- HREADYOUT  out  1  ready feedback
- HRESP  out  2  response: 00 OKAY, 01 ERROR
- ERR_VALID  out  1  sticky: a fault has been logged
- ERR_OVF  out  1  sticky: a further fault occurred while ERR_VALID was set
- ERR_ADDR  out  ADDR_WIDTH  HADDR of the first logged fault
- ERR_WRITE  out  1  HWRITE of the first logged fault
- ERR_COUNT  out  CNT_WIDTH  faults since reset/clear, saturating
- IRQ  out  1  level interrupt, equal to ERR_VALID

## Operation
- invalid = HSEL & HREADY & HTRANS[1]; an invalid transfer is accepted only while HREADYOUT=1 (IDLE or ERR2). IDLE/BUSY transfers always receive zero-wait OKAY.
- FSM states are IDLE, WAIT, ERR1 and ERR2. All outputs are registered.
  - IDLE: HREADYOUT=1, HRESP=OKAY. On invalid, go to WAIT (load wait counter with WAIT_STATES-1) if WAIT_STATES>0, else go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=OKAY. Decrement the counter; go to ERR1 when it reaches 0.
  - ERR1: HREADYOUT=0, HRESP=ERROR. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR. On invalid, re-enter WAIT/ERR1 as from IDLE (back-to-back faults); otherwise go to IDLE.
- Log capture happens on acceptance of an invalid transfer (address phase):
  - If ERR_VALID=0: latch HADDR into ERR_ADDR and HWRITE into ERR_WRITE, and set ERR_VALID.
  - If ERR_VALID=1: ERR_ADDR and ERR_WRITE are held, and ERR_OVF is set.
  - In both cases ERR_COUNT increments, saturating at all-ones.
- ERR_CLR clears ERR_VALID, ERR_OVF and ERR_COUNT; ERR_ADDR and ERR_WRITE are held. ERR_CLR has no effect on the bus FSM.
- Clear coinciding with a capture: the capture wins. Result is ERR_VALID=1, ERR_OVF=0, ERR_COUNT=1, with the new address and direction latched.

## Timing
- Reset values: HREADYOUT=1, HRESP=00, FSM=IDLE, wait counter=0, ERR_VALID=0, ERR_OVF=0, ERR_ADDR=0, ERR_WRITE=0, ERR_COUNT=0, IRQ=0.
- Address phase of the faulting transfer is in cycle N.
  - WAIT_STATES=0: cycle N+1 gives (HREADYOUT,HRESP)=(0,01); cycle N+2 gives (1,01).
  - WAIT_STATES=W: cycles N+1..N+W give (0,00); cycle N+W+1 gives (0,01); cycle N+W+2 gives (1,01).
- Log outputs update at the edge ending cycle N, so they are visible in cycle N+1. IRQ follows ERR_VALID with zero extra latency.
- A transfer with HSEL=1 while HREADY=0 is ignored; there is no capture and no state change.
- HRESETn asserted mid-response forces IDLE and reset values asynchronously. The response in flight is abandoned.

## Structure
- Shared package `ahb_pkg` holds the HRESP encodings (RSP_OKAY=2'b00, RSP_ERROR=2'b01), the HTRANS encodings, and the FSM state enum `dslv_state_t`.
- One sub-module, `ahb_errlog_capture`, contains the capture/clear/saturating-count logic. It takes a capture strobe, addr, write and clr as inputs and drives the five log outputs. The top level holds the FSM and the wait counter.
- Elaboration-time check: WAIT_STATES must be ≤15, CNT_WIDTH ≥1 and ADDR_WIDTH ≥1.

## Test plan
- WAIT_STATES=0; NONSEQ to HADDR=0x4000_0010, HWRITE=1 -> (0,01) then (1,01). ERR_ADDR=0x4000_0010, ERR_WRITE=1, ERR_VALID=1, IRQ=1, ERR_COUNT=1.
- WAIT_STATES=3; NONSEQ read -> three cycles of (0,00), then (0,01), then (1,01). ERR_WRITE=0.
- Back-to-back NONSEQ during ERR2 at 0x100 then 0x200 -> two full ERROR responses with no IDLE gap. ERR_ADDR=0x100, ERR_OVF=1, ERR_COUNT=2.
- CNT_WIDTH=2; issue 5 faults -> ERR_COUNT holds at 3. Then ERR_CLR coinciding with a sixth fault at 0x300 -> ERR_COUNT=1, ERR_OVF=0, ERR_ADDR=0x300.
- IDLE/BUSY with HSEL=1, and NONSEQ with HREADY=0 -> HREADYOUT stays 1, HRESP stays 00, no log change.
- Assert HRESETn low during ERR1 -> HREADYOUT=1, HRESP=00 and all log outputs 0 immediately. The next NONSEQ after release gets a normal ERROR response.
